// File: rtl/regfile_dbg_port_if.sv
// Host-facing command/response channel of the register-file debug port.
// The host drives commands and accepts responses (master); the debug
// engine accepts commands and produces responses (slave).
interface regfile_dbg_port_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [4:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_rdata,
    input  rsp_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_rdata,
    output rsp_err
  );
endinterface

// File: rtl/regfile_dbg_port.sv
// Debug access engine for the 32x32 register file of the multicycle RV32 core.
// A host command is latched, the core is asked to halt, and once the core
// acknowledges the engine owns the register-file ports for exactly one cycle
// to perform the read or write. The result is then offered on the response
// channel while the core is kept halted. If the core never acknowledges
// within HALT_TIMEOUT cycles an error response is returned without touching
// the register file.
module regfile_dbg_port #(
  parameter int unsigned HALT_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_dbg_port_if.slave        dbg,
  output logic                     halt_req,
  input  logic                     halt_ack,
  output logic                     rf_sel,
  output logic [4:0]               rf_A1,
  input  logic [31:0]              rf_RD1,
  output logic [4:0]               rf_A3,
  output logic [31:0]              rf_WD3,
  output logic                     rf_RegWrite
);

  typedef enum logic [1:0] {
    IDLE,
    HALT,
    ACCESS,
    RESP
  } state_t;

  // The timeout counter is 8 bits wide, so the limit is truncated to match.
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(HALT_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        lat_write_q, lat_write_d;
  logic [4:0]  lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [7:0]  cnt_inc;

  logic        cmd_ready_c;
  logic        rsp_valid_c;
  logic        halt_req_c;
  logic        rf_sel_c;
  logic        rf_we_c;

  assign cnt_inc = cnt_q + 8'd1;

  // Next-state and output decode: every target gets a hold/idle default
  // first, then each state overrides only what it changes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_write_d = lat_write_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    cmd_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    halt_req_c  = 1'b0;
    rf_sel_c    = 1'b0;
    rf_we_c     = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_c = 1'b1;
        if (dbg.cmd_valid) begin
          lat_write_d = dbg.cmd_write;
          lat_addr_d  = dbg.cmd_addr;
          lat_wdata_d = dbg.cmd_wdata;
          cnt_d       = 8'd0;
          state_d     = HALT;
        end
      end

      HALT: begin
        halt_req_c = 1'b1;
        if (halt_ack) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_LIMIT) begin
            rdata_d = 32'h0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      ACCESS: begin
        halt_req_c = 1'b1;
        rf_sel_c   = 1'b1;
        rf_we_c    = lat_write_q;
        rdata_d    = lat_write_q ? 32'h0 : rf_RD1;
        err_d      = 1'b0;
        state_d    = RESP;
      end

      RESP: begin
        halt_req_c  = 1'b1;
        rsp_valid_c = 1'b1;
        if (dbg.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any command in flight and
  // clears everything visible on the ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      lat_write_q <= 1'b0;
      lat_addr_q  <= 5'd0;
      lat_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_write_q <= lat_write_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Control strobes are masked by reset so that a reset arriving during
  // ACCESS cannot let the register file commit a write on that edge, and
  // no command is accepted while reset is held.
  assign dbg.cmd_ready = cmd_ready_c & ~reset;
  assign dbg.rsp_valid = rsp_valid_c & ~reset;
  assign halt_req      = halt_req_c  & ~reset;
  assign rf_sel        = rf_sel_c    & ~reset;
  assign rf_RegWrite   = rf_we_c     & ~reset;

  // Response payload comes straight from registers, so it cannot change
  // while the host is applying backpressure.
  assign dbg.rsp_rdata = rdata_q;
  assign dbg.rsp_err   = err_q;

  // Address and data lines carry the latched command at all times; the
  // top-level mux only looks at them while rf_sel is high.
  assign rf_A1  = lat_addr_q;
  assign rf_A3  = lat_addr_q;
  assign rf_WD3 = lat_wdata_q;

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Directed testbench for regfile_dbg_port with a small register-file model
// on the rf_* side and a response scoreboard on the host side.
module tb_regfile_dbg_port;

  localparam int unsigned TIMEOUT = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        halt_req;
  logic        halt_ack;
  logic        rf_sel;
  logic [4:0]  rf_A1;
  logic [31:0] rf_RD1;
  logic [4:0]  rf_A3;
  logic [31:0] rf_WD3;
  logic        rf_RegWrite;

  logic        tb_init;
  logic [31:0] mem [32];
  logic [31:0] shadow [32];
  rsp_t        exp_q [$];

  int          assert_count = 0;
  int          fail_count = 0;
  int          sel_count = 0;
  int          we_count = 0;
  logic [4:0]  last_a3 = 5'd0;
  logic [31:0] last_wd3 = 32'h0;

  regfile_dbg_port_if dbg_bus ();

  regfile_dbg_port #(.HALT_TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .dbg         (dbg_bus.slave),
    .halt_req    (halt_req),
    .halt_ack    (halt_ack),
    .rf_sel      (rf_sel),
    .rf_A1       (rf_A1),
    .rf_RD1      (rf_RD1),
    .rf_A3       (rf_A3),
    .rf_WD3      (rf_WD3),
    .rf_RegWrite (rf_RegWrite)
  );

  always #5 clk = ~clk;

  // Register file model: x0 reads as zero, writes land on the rising edge.
  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[5] <= 32'hDEADBEEF;
    end else if (rf_sel && rf_RegWrite) begin
      mem[rf_A3] <= rf_WD3;
    end
  end

  assign rf_RD1 = (rf_A1 == 5'd0) ? 32'h0 : mem[rf_A1];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Monitor: counts register-file strobes and scores each response handshake.
  always @(negedge clk) begin
    rsp_t e;
    if (!reset) begin
      if (rf_sel) sel_count++;
      if (rf_RegWrite) begin
        we_count++;
        last_a3  = rf_A3;
        last_wd3 = rf_WD3;
      end
      if (dbg_bus.rsp_valid && dbg_bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          assert_count++;
          fail_count++;
          $error("[TB] FAIL unexpected_rsp: observed a response (rdata 0x%08h), expected none",
                 dbg_bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_rdata", dbg_bus.rsp_rdata, e.rdata);
          checkOutput("rsp_err", {31'b0, dbg_bus.rsp_err}, {31'b0, e.err});
        end
      end
    end
  end

  // Drive one command (called just after a rising edge); returns just after
  // the accepting edge with the expected response queued if one is due.
  task automatic applyStimulus(input logic wr, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic expect_rsp,
                               input logic expect_err);
    int   waited = 0;
    logic accepted = 1'b0;
    rsp_t e;
    dbg_bus.cmd_valid = 1'b1;
    dbg_bus.cmd_write = wr;
    dbg_bus.cmd_addr  = addr;
    dbg_bus.cmd_wdata = wdata;
    while (waited < 20) begin
      @(negedge clk);
      if (dbg_bus.cmd_ready) begin
        accepted = 1'b1;
        break;
      end
      waited++;
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    dbg_bus.cmd_valid = 1'b0;
    if (!accepted) begin
      assert_count++;
      fail_count++;
      $error("[TB] FAIL cmd_accept: observed no cmd_ready in 20 cycles, expected acceptance");
    end else if (expect_rsp) begin
      if (expect_err) begin
        e.rdata = 32'h0;
        e.err   = 1'b1;
      end else if (wr) begin
        if (addr != 5'd0) shadow[addr] = wdata;
        e.rdata = 32'h0;
        e.err   = 1'b0;
      end else begin
        e.rdata = shadow[addr];
        e.err   = 1'b0;
      end
      exp_q.push_back(e);
    end
  endtask

  // Count whole cycles until rsp_valid; returns at the falling edge where it is seen.
  task automatic waitResponse(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (dbg_bus.rsp_valid) break;
      cycles++;
      if (cycles > 40) begin
        assert_count++;
        fail_count++;
        $error("[TB] FAIL rsp_wait: observed no rsp_valid in 40 cycles, expected a response");
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int sel0;
    int we0;

    reset             = 1'b1;
    tb_init           = 1'b1;
    halt_ack          = 1'b0;
    dbg_bus.cmd_valid = 1'b0;
    dbg_bus.cmd_write = 1'b0;
    dbg_bus.cmd_addr  = 5'd0;
    dbg_bus.cmd_wdata = 32'h0;
    dbg_bus.rsp_ready = 1'b1;
    for (int i = 0; i < 32; i++) shadow[i] = 32'h0;
    shadow[5] = 32'hDEADBEEF;

    $display("[TB] reset");
    nextCycle();
    @(negedge clk);
    checkOutput("cmd_ready_in_reset", {31'b0, dbg_bus.cmd_ready}, 32'h0);
    nextCycle();
    reset   = 1'b0;
    tb_init = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", {31'b0, dbg_bus.cmd_ready}, 32'h1);
    checkOutput("rst_rsp_valid", {31'b0, dbg_bus.rsp_valid}, 32'h0);
    checkOutput("rst_rsp_err", {31'b0, dbg_bus.rsp_err}, 32'h0);
    checkOutput("rst_rsp_rdata", dbg_bus.rsp_rdata, 32'h0);
    checkOutput("rst_halt_req", {31'b0, halt_req}, 32'h0);
    checkOutput("rst_rf_sel", {31'b0, rf_sel}, 32'h0);
    checkOutput("rst_rf_we", {31'b0, rf_RegWrite}, 32'h0);
    checkOutput("rst_rf_A1", {27'b0, rf_A1}, 32'h0);
    checkOutput("rst_rf_WD3", rf_WD3, 32'h0);
    nextCycle();

    $display("[TB] read x5 with halt_ack high");
    halt_ack = 1'b1;
    sel0 = sel_count;
    applyStimulus(1'b0, 5'd5, 32'h0, 1'b1, 1'b0);
    waitResponse(n);
    checkOutput("read_latency", n, 2);
    nextCycle();
    checkOutput("rf_sel_pulses", sel_count - sel0, 1);
    @(negedge clk);
    checkOutput("cmd_ready_after_rsp", {31'b0, dbg_bus.cmd_ready}, 32'h1);
    checkOutput("halt_req_after_rsp", {31'b0, halt_req}, 32'h0);
    nextCycle();

    $display("[TB] write x7 then read x7");
    we0 = we_count;
    applyStimulus(1'b1, 5'd7, 32'h12345678, 1'b1, 1'b0);
    waitResponse(n);
    checkOutput("write_latency", n, 2);
    nextCycle();
    checkOutput("write_pulses", we_count - we0, 1);
    checkOutput("write_addr", {27'b0, last_a3}, 32'd7);
    checkOutput("write_data", last_wd3, 32'h12345678);
    applyStimulus(1'b0, 5'd7, 32'h0, 1'b1, 1'b0);
    waitResponse(n);
    nextCycle();

    $display("[TB] write x0 then read x0");
    we0 = we_count;
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0);
    waitResponse(n);
    nextCycle();
    checkOutput("x0_write_pulses", we_count - we0, 1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    waitResponse(n);
    nextCycle();

    $display("[TB] halt timeout");
    halt_ack = 1'b0;
    we0  = we_count;
    sel0 = sel_count;
    applyStimulus(1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 1'b1);
    waitResponse(n);
    checkOutput("timeout_cycles", n, TIMEOUT);
    nextCycle();
    checkOutput("timeout_no_write", we_count - we0, 0);
    checkOutput("timeout_no_sel", sel_count - sel0, 0);

    $display("[TB] ack in last halt cycle");
    applyStimulus(1'b0, 5'd7, 32'h0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    halt_ack = 1'b1;
    waitResponse(n);
    checkOutput("late_ack_latency", n + 3, TIMEOUT + 1);
    nextCycle();

    $display("[TB] response backpressure");
    dbg_bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 5'd5, 32'h0, 1'b1, 1'b0);
    waitResponse(n);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("bp_rsp_valid", {31'b0, dbg_bus.rsp_valid}, 32'h1);
      checkOutput("bp_rsp_rdata", dbg_bus.rsp_rdata, 32'hDEADBEEF);
      checkOutput("bp_rsp_err", {31'b0, dbg_bus.rsp_err}, 32'h0);
      checkOutput("bp_halt_req", {31'b0, halt_req}, 32'h1);
    end
    nextCycle();
    dbg_bus.rsp_ready = 1'b1;
    nextCycle();
    @(negedge clk);
    checkOutput("bp_cmd_ready_after", {31'b0, dbg_bus.cmd_ready}, 32'h1);
    nextCycle();

    $display("[TB] reset during write access");
    we0 = we_count;
    applyStimulus(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 1'b0);
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_access_we", {31'b0, rf_RegWrite}, 32'h0);
    checkOutput("rst_access_cmd_ready", {31'b0, dbg_bus.cmd_ready}, 32'h0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_rsp_valid", {31'b0, dbg_bus.rsp_valid}, 32'h0);
    checkOutput("post_rst_halt_req", {31'b0, halt_req}, 32'h0);
    checkOutput("post_rst_rf_sel", {31'b0, rf_sel}, 32'h0);
    checkOutput("post_rst_rf_A3", {27'b0, rf_A3}, 32'h0);
    checkOutput("post_rst_rf_WD3", rf_WD3, 32'h0);
    checkOutput("post_rst_cmd_ready", {31'b0, dbg_bus.cmd_ready}, 32'h1);
    checkOutput("rst_no_write", we_count - we0, 0);
    nextCycle();
    applyStimulus(1'b0, 5'd9, 32'h0, 1'b1, 1'b0);
    waitResponse(n);
    nextCycle();
    repeat (3) nextCycle();

    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
